// File: rtl/reset_pkg.sv
// Shared encodings and limits for the reset sequencer and its helpers.
package reset_pkg;

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_DEB      = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    typedef enum logic [1:0] {
        HOLD     = ST_HOLD,
        RUN      = ST_RUN,
        DEB      = ST_DEB,
        WAIT_REL = ST_WAIT_REL
    } state_e;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 2;
    localparam int MIN_HOLD_CYCLES     = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous bit, with synchronous active-low clear.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Combines system reset with a debounced push-button request and stretches the
// resulting active-high synchronous reset for a fixed number of cycles on exit.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_req_async,
    output logic rst_out,
    output logic rst_done
);

    // Out-of-range parameters are raised to the smallest value that still works.
    localparam int SYNC_N = max_int(SYNC_STAGES, MIN_SYNC_STAGES);
    localparam int DEB_N  = max_int(DEBOUNCE_CYCLES, MIN_DEBOUNCE_CYCLES);
    localparam int HOLD_N = max_int(HOLD_CYCLES, MIN_HOLD_CYCLES);
    localparam int CNT_W  = $clog2(max_int(DEB_N, HOLD_N) + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic req_sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_out_q, rst_out_d;
    logic             rst_done_q, rst_done_d;

    bit_synchronizer #(
        .STAGES(SYNC_N)
    ) u_req_sync (
        .clk  (clk),
        .clr_n(reset),
        .d    (rst_req_async),
        .q    (req_sync)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_out_d  = rst_out_q;
        rst_done_d = 1'b0;

        case (state_q)
            HOLD: begin
                rst_out_d = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    rst_out_d  = 1'b0;
                    rst_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                rst_out_d = 1'b0;
                // The sample that enters DEB is the first of the debounce run.
                if (req_sync) begin
                    state_d = DEB;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB: begin
                rst_out_d = 1'b0;
                if (!req_sync) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = WAIT_REL;
                    rst_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_REL: begin
                // rst_out stays high straight into HOLD, so there is no one-cycle dip.
                rst_out_d = 1'b1;
                if (!req_sync) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d   = HOLD;
                cnt_d     = '0;
                rst_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign rst_done = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: per-edge expected {rst_out, rst_done} derived from the documented latencies.
module tb_reset_sequencer;

    localparam int S = 2;
    localparam int D = 16;
    localparam int H = 8;

    logic clk;
    logic reset;
    logic rst_req_async;
    logic rst_out;
    logic rst_done;

    logic [1:0] exp_q[$];
    int tests;
    int failed;

    reset_sequencer #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rst_req_async(rst_req_async),
        .rst_out      (rst_out),
        .rst_done     (rst_done)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic drive_cycle(input logic rst_n_v, input logic req_v);
        reset         = rst_n_v;
        rst_req_async = req_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(2'b10);
            drive_cycle(1'b0, 1'b0);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL reset_low edge %0d: got out/done=%b expected %b", k, {rst_out, rst_done}, e);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            if (k < H) exp_q.push_back(2'b10);
            else if (k == H) exp_q.push_back(2'b01);
            else exp_q.push_back(2'b00);
            drive_cycle(1'b1, 1'b0);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL power_on edge %0d: got out/done=%b expected %b", k, {rst_out, rst_done}, e);
            end
        end
    endtask

    // Press of p driven-high edges starting from RUN with the synchroniser idle.
    task automatic test_press(input string name, input int p, input int total);
        logic [1:0] e;
        logic eo;
        logic ed;
        for (int k = 1; k <= total; k++) begin
            eo = 1'b0;
            ed = 1'b0;
            if (p >= D) begin
                eo = (k >= D + S) && (k <= p + S + H);
                ed = (k == p + S + 1 + H);
            end
            exp_q.push_back({eo, ed});
            drive_cycle(1'b1, k <= p);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL %s p=%0d edge %0d: got out/done=%b expected %b", name, p, k, {rst_out, rst_done}, e);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [1:0] e;
        // Request rises at edge 1; DEB holds cnt=10 after edge 12; reset sampled at edge 13.
        for (int k = 1; k <= 30; k++) begin
            if (k <= 12) exp_q.push_back(2'b00);
            else if (k < 13 + H) exp_q.push_back(2'b10);
            else if (k == 13 + H) exp_q.push_back(2'b01);
            else exp_q.push_back(2'b00);
            drive_cycle((k == 13) ? 1'b0 : 1'b1, k <= 12);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL mid_debounce edge %0d: got out/done=%b expected %b", k, {rst_out, rst_done}, e);
            end
        end
    endtask

    task automatic test_req_across_reset();
        logic [1:0] e;
        int rel;
        rel = 40;
        for (int k = 1; k <= 2; k++) begin
            exp_q.push_back(2'b10);
            drive_cycle(1'b0, 1'b1);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL across_reset_low edge %0d: got out/done=%b expected %b", k, {rst_out, rst_done}, e);
            end
        end
        for (int k = 1; k <= rel + 16; k++) begin
            if (k < H) exp_q.push_back(2'b10);
            else if (k == H) exp_q.push_back(2'b01);
            else if (k < H + D) exp_q.push_back(2'b00);
            else if (k <= rel + S + H) exp_q.push_back(2'b10);
            else if (k == rel + S + 1 + H) exp_q.push_back(2'b01);
            else exp_q.push_back(2'b00);
            drive_cycle(1'b1, k <= rel);
            e = exp_q.pop_front();
            tests++;
            if ({rst_out, rst_done} !== e) begin
                failed++;
                $display("FAIL across_reset edge %0d: got out/done=%b expected %b", k, {rst_out, rst_done}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p1;
        int g;
        int p2;
        p1 = $urandom_range(D + 1, 30);
        g  = $urandom_range(1, D - 2);
        p2 = $urandom_range(D, 30);
        test_press("b2b_first", p1, p1 + S + H + 1);
        test_press("b2b_glitch", g, g + S + 2);
        test_press("b2b_second", p2, p2 + S + H + 4);
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        reset         = 1'b0;
        rst_req_async = 1'b0;
        test_reset();
        test_press("glitch", 5, 14);
        test_press("deb_15", D - 1, 24);
        test_press("deb_16", D, 32);
        test_press("full_press", 40, 56);
        test_reset_mid_debounce();
        test_req_across_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
